// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: turns byte/half/word accesses into aligned
// word accesses on DataMemory. Sub-word stores use read-modify-write, and sub-word
// loads are extracted and extended. Big-endian byte order.
module load_store_unit #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        addr_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_readData
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_store, r_unsigned, r_err;
  logic [1:0]  r_size, r_off;
  logic [3:0]  r_cnt;
  logic [31:0] r_wdata, r_addr, r_rdata;

  logic        w_misaligned, w_read_last, w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_merged, w_load;

  // Size 11 behaves as a word access.
  assign w_misaligned = (req_size == 2'b01 && req_addr[0]) ||
                        (req_size[1] && req_addr[1:0] != 2'b00);
  assign w_word       = r_size[1];
  assign w_read_last  = (r_cnt == 4'(READ_LATENCY - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          if (w_misaligned)                  w_state_next = StDone;
          else if (req_store && req_size[1]) w_state_next = StWrite;
          else                               w_state_next = StRead;
        end
      end
      StRead:  if (w_read_last) w_state_next = r_store ? StWrite : StDone;
      StWrite: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Request latch, read-latency counter and sampled memory word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store    <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_cnt      <= 4'd0;
      r_wdata    <= 32'd0;
      r_addr     <= 32'd0;
      r_rdata    <= 32'd0;
    end else begin
      if (r_state == StIdle && req_valid) begin
        r_store    <= req_store;
        r_unsigned <= req_unsigned;
        r_err      <= w_misaligned;
        r_size     <= req_size;
        r_off      <= req_addr[1:0];
        r_cnt      <= 4'd0;
        r_wdata    <= req_wdata;
        r_addr     <= {req_addr[31:2], 2'b00};
      end else if (r_state == StRead) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_read_last) r_rdata <= mem_readData;
      end
    end
  end

  // Store merge: replace the addressed byte/half of the sampled word.
  always_comb begin
    w_merged = r_rdata;
    if (r_size == 2'b00) begin
      unique case (r_off)
        2'd0: w_merged[31:24] = r_wdata[7:0];
        2'd1: w_merged[23:16] = r_wdata[7:0];
        2'd2: w_merged[15:8]  = r_wdata[7:0];
        2'd3: w_merged[7:0]   = r_wdata[7:0];
        default: w_merged = r_rdata;
      endcase
    end else if (r_size == 2'b01) begin
      if (r_off[1]) w_merged[15:0]  = r_wdata[15:0];
      else          w_merged[31:16] = r_wdata[15:0];
    end
  end

  // Load extraction and sign/zero extension.
  always_comb begin
    unique case (r_off)
      2'd0:    w_byte = r_rdata[31:24];
      2'd1:    w_byte = r_rdata[23:16];
      2'd2:    w_byte = r_rdata[15:8];
      default: w_byte = r_rdata[7:0];
    endcase
    w_half = r_off[1] ? r_rdata[15:0] : r_rdata[31:16];
    if (w_word)
      w_load = r_rdata;
    else if (r_size[0])
      w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
    else
      w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
  end

  // Outputs decode straight from state so reset drops strobes asynchronously.
  always_comb begin
    stall         = (r_state == StIdle && req_valid) || r_state == StRead || r_state == StWrite;
    mem_read      = (r_state == StRead);
    mem_write     = (r_state == StWrite);
    mem_address   = r_addr;
    mem_writeData = mem_write ? (w_word ? r_wdata : w_merged) : 32'd0;
    resp_valid    = (r_state == StDone) && !r_store && !r_err;
    resp_rdata    = resp_valid ? w_load : 32'd0;
    addr_error    = (r_state == StDone) && r_err;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-request schedule model plus word-memory model,
// checked every cycle, with literal expectations on key results.
module tb_load_store_unit;
  localparam int unsigned L = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, resp_valid, addr_error, mem_write, mem_read;
  logic [31:0] resp_rdata, mem_address, mem_writeData, mem_readData;

  load_store_unit #(.READ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .addr_error(addr_error), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_write(mem_write), .mem_read(mem_read),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // DataMemory stand-in (combinational read) and the reference copy of it.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int n_wr = 0;
  assign mem_readData = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_writeData;
  always @(posedge clk) if (mem_write) n_wr <= n_wr + 1;

  typedef struct packed {
    logic        en, stall, rd, wr, rv, err, chk_addr;
    logic [31:0] addr, wdata, rdata;
  } exp_t;
  exp_t ex;

  int n_checks = 0, n_fail = 0;
  logic [31:0] last_rdata = '0, last_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the expected record.
  always @(negedge clk) begin
    if (ex.en) begin
      chk("stall", 32'(stall), 32'(ex.stall));
      chk("mem_read", 32'(mem_read), 32'(ex.rd));
      chk("mem_write", 32'(mem_write), 32'(ex.wr));
      chk("resp_valid", 32'(resp_valid), 32'(ex.rv));
      chk("addr_error", 32'(addr_error), 32'(ex.err));
      if (ex.chk_addr) chk("mem_address", mem_address, ex.addr);
      if (ex.rv) begin
        chk("resp_rdata", resp_rdata, ex.rdata);
        last_rdata = resp_rdata;
      end
      if (ex.wr) begin
        chk("mem_writeData", mem_writeData, ex.wdata);
        last_wdata = mem_writeData;
      end
    end
  end

  // Big-endian field position: offset 0 is the most significant byte.
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * (3 - int'(off))));
    h = 16'(w >> (16 * (1 - int'(off[1]))));
    if (sz[1])      return w;
    else if (sz[0]) return uns ? 32'(h) : 32'($signed(h));
    else            return uns ? 32'(b) : 32'($signed(b));
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [31:0] wd, input logic [1:0] off);
    int sh;
    logic [31:0] mask;
    if (sz[1]) return wd;
    if (sz[0]) begin
      sh = 16 * (1 - int'(off[1]));
      mask = 32'h0000FFFF << sh;
      return (w & ~mask) | ((wd & 32'h0000FFFF) << sh);
    end
    sh = 8 * (3 - int'(off));
    mask = 32'h000000FF << sh;
    return (w & ~mask) | ((wd & 32'h000000FF) << sh);
  endfunction

  // Issue one request and set the expected outputs for every cycle until DONE.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    logic mis;
    int n, idx;
    logic [31:0] nw, lv;
    idx = int'(a[9:2]);
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    nw  = store_val(ref_mem[idx], sz, wd, a[1:0]);
    lv  = load_val(ref_mem[idx], sz, uns, a[1:0]);
    n   = mis ? 1 : (!st ? int'(L) + 1 : (sz[1] ? 2 : int'(L) + 2));
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    for (int c = 0; c <= n; c++) begin
      ex = '0;
      ex.en = 1'b1;
      ex.stall = (c < n);
      ex.chk_addr = (c >= 1);
      ex.addr = {a[31:2], 2'b00};
      if (!mis) begin
        if (c >= 1 && c <= int'(L) && !(st && sz[1])) ex.rd = 1'b1;
        if (st && c == n - 1) begin
          ex.wr = 1'b1;
          ex.wdata = nw;
        end
      end
      if (c == n) begin
        ex.err = mis;
        ex.rv = !mis && !st;
        ex.rdata = lv;
      end
      @(posedge clk); #1;
    end
    if (!mis && st) ref_mem[idx] = nw;
  endtask

  task automatic idle(input int cycles);
    req_valid = 1'b0;
    ex = '0;
    ex.en = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  int wr_before;

  initial begin
    ex = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_read", 32'(mem_read), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset addr_error", 32'(addr_error), 32'd0);
    chk("reset mem_address", mem_address, 32'd0);
    chk("reset mem_writeData", mem_writeData, 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Word load
    set_word(64, 32'hDEADBEEF);
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("lw literal", last_rdata, 32'hDEADBEEF);
    idle(1);

    // Byte/half loads
    set_word(64, 32'h12F45678);
    do_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    chk("lb literal", last_rdata, 32'hFFFFFFF4);
    do_op(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
    chk("lbu literal", last_rdata, 32'h000000F4);
    do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    chk("lh literal", last_rdata, 32'h00005678);
    do_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
    chk("lb off0 literal", last_rdata, 32'h00000012);
    idle(1);

    // Sub-word stores
    do_op(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AA);
    chk("sb literal", last_wdata, 32'h12F456AA);
    idle(1);
    set_word(64, 32'h12F45678);
    do_op(1'b1, 2'b01, 1'b0, 32'h100, 32'h0000BEEF);
    chk("sh literal", last_wdata, 32'hBEEF5678);
    chk("sh memory", mem[64], 32'hBEEF5678);
    do_op(1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
    chk("lh neg literal", last_rdata, 32'hFFFFBEEF);
    do_op(1'b0, 2'b01, 1'b1, 32'h100, 32'h0);
    chk("lhu literal", last_rdata, 32'h0000BEEF);
    do_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h00000033);
    chk("sb off1 literal", last_wdata, 32'hBE335678);
    idle(1);

    // Misaligned
    wr_before = n_wr;
    do_op(1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    do_op(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000FFFF);
    do_op(1'b1, 2'b11, 1'b0, 32'h105, 32'h01234567);
    idle(1);
    chk("misaligned no writes", 32'(n_wr), 32'(wr_before));

    // Reset during the READ of a byte store
    set_word(64, 32'h12F45678);
    wr_before = n_wr;
    ex = '0;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h102; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    chk("rst-mid mem_read before", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst-mid mem_read", 32'(mem_read), 32'd0);
    chk("rst-mid stall", 32'(stall), 32'd0);
    chk("rst-mid mem_write", 32'(mem_write), 32'd0);
    chk("rst-mid mem_address", mem_address, 32'd0);
    chk("rst-mid resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst-mid no write", 32'(n_wr), 32'(wr_before));
    chk("rst-mid memory", mem[64], 32'h12F45678);
    idle(1);
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    chk("lw after reset", last_rdata, 32'h12F45678);

    // Back-to-back, no idle gap
    do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    do_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D);
    chk("sw literal", last_wdata, 32'hCAFEF00D);
    do_op(1'b0, 2'b00, 1'b1, 32'h107, 32'h0);
    chk("lbu b2b literal", last_rdata, 32'h0000000D);
    idle(2);

    ex = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
